// File: rtl/reg_bank_pkg.sv
// Shared defaults, word type and address range helper for the register bank.
package reg_bank_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef logic [DEF_WIDTH-1:0] word_t;

    // True when addr selects an existing entry; DEPTH need not be a power of 2.
    function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/reg_bank_entry.sv
// One register-bank word plus its valid bit, falling-edge clocked.
// Flush wins over load; clear (active low) empties the entry asynchronously.
module reg_bank_entry #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             vld
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q,  vld_d;

    // Next state: flush empties, load stores and marks valid, otherwise hold.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush) begin
            data_d = '0;
            vld_d  = 1'b0;
        end else if (load) begin
            data_d = d;
            vld_d  = 1'b1;
        end
    end

    // State register on the falling edge with asynchronous clear.
    always_ff @(negedge clk or negedge clear) begin
        if (!clear) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q   = data_q;
    assign vld = vld_q;

endmodule

// File: rtl/reg_bank_neg.sv
// Register bank: DEPTH x WIDTH words, one write port, two combinational read
// ports, per-entry valid bits and an occupancy counter. Negedge clocked.
// Optional feature macro REG_BANK_ZERO0_EN: entry 0 is hard-wired to zero,
// always valid, ignores writes and is permanently counted in occupancy.
module reg_bank_neg
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             flush,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] x,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] z_a,
    output logic [WIDTH-1:0] z_b,
    output logic             valid_a,
    output logic             valid_b,
    output logic [AW:0]      occupancy
);

`ifdef REG_BANK_ZERO0_EN
    localparam int FIRST = 1;   // entry 0 is a constant, not a register
`else
    localparam int FIRST = 0;
`endif
    localparam logic [AW:0] OCC_BASE = (AW+1)'(FIRST);
    localparam logic [AW:0] OCC_MAX  = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0]            we_vec;
    logic                        wr_ok;
    logic                        new_entry;
    logic [AW:0]                 occ_q, occ_d;

    assign wr_ok = addr_ok(32'(wr_addr), DEPTH);

    // Write decode: one-hot enable, suppressed by flush, range and entry 0 under ZERO0.
    always_comb begin
        we_vec = '0;
        for (int i = FIRST; i < DEPTH; i++) begin
            we_vec[i] = load && !flush && wr_ok && (wr_addr == AW'(i));
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            if (gi < FIRST) begin : g_zero
                assign mem[gi] = '0;
                assign vld[gi] = 1'b1;
            end else begin : g_reg
                reg_bank_entry #(.WIDTH(WIDTH)) u_entry (
                    .clk   (clk),
                    .clear (clear),
                    .load  (we_vec[gi]),
                    .flush (flush),
                    .d     (x),
                    .q     (mem[gi]),
                    .vld   (vld[gi])
                );
            end
        end
    endgenerate

    // Read muxes: out-of-range addresses match no entry and return 0/invalid.
    always_comb begin
        z_a     = '0;
        z_b     = '0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == AW'(i)) begin
                z_a     = mem[i];
                valid_a = vld[i];
            end
            if (rd_addr_b == AW'(i)) begin
                z_b     = mem[i];
                valid_b = vld[i];
            end
        end
    end

    // A write counts only when it lands on a currently invalid entry.
    assign new_entry = |(we_vec & ~vld);

    // Occupancy next state: flush restores the base, new entries add one, capped at DEPTH.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = OCC_BASE;
        end else if (new_entry && (occ_q < OCC_MAX)) begin
            occ_d = occ_q + (AW+1)'(1);
        end
    end

    // Occupancy register, falling edge with asynchronous clear.
    always_ff @(negedge clk or negedge clear) begin
        if (!clear) occ_q <= OCC_BASE;
        else        occ_q <= occ_d;
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_reg_bank_neg.sv
// Directed self-checking bench for reg_bank_neg (WIDTH=8, DEPTH=4).
// Inputs change on the rising edge; the DUT updates on the falling edge.
module tb_reg_bank_neg;
    import reg_bank_pkg::*;

`ifdef REG_BANK_ZERO0_EN
    localparam logic [2:0] OCC0 = 3'd1;
`else
    localparam logic [2:0] OCC0 = 3'd0;
`endif

    logic       clk, clear, load, flush;
    logic [1:0] wr_addr, rd_addr_a, rd_addr_b;
    word_t      x, z_a, z_b;
    logic       valid_a, valid_b;
    logic [2:0] occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    reg_bank_neg #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .clear     (clear),
        .load      (load),
        .flush     (flush),
        .wr_addr   (wr_addr),
        .x         (x),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .z_a       (z_a),
        .z_b       (z_b),
        .valid_a   (valid_a),
        .valid_b   (valid_b),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic write(input logic [1:0] a, input word_t d);
        @(posedge clk);
        wr_addr = a;
        x       = d;
        load    = 1'b1;
        @(negedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if (z_a !== 8'h00 || z_b !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_z: z_a=%h z_b=%h expected 00/00", z_a, z_b);
        end
        n_checks++;
        if (occupancy !== OCC0) begin
            n_fail++;
            $display("FAIL reset_occ: got %0d expected %0d", occupancy, OCC0);
        end
        repeat (2) @(posedge clk);
        clear = 1'b1;
    endtask

    task automatic test_write;
        write(2'd1, 8'hA5);
        write(2'd2, 8'h3C);
        rd_addr_a = 2'd1;
        rd_addr_b = 2'd2;
        #1;
        n_checks++;
        if (z_a !== 8'hA5 || z_b !== 8'h3C || valid_a !== 1'b1 || valid_b !== 1'b1) begin
            n_fail++;
            $display("FAIL write_read: z_a=%h z_b=%h va=%b vb=%b expected A5 3C 1 1",
                     z_a, z_b, valid_a, valid_b);
        end
        n_checks++;
        if (occupancy !== OCC0 + 3'd2) begin
            n_fail++;
            $display("FAIL write_occ: got %0d expected %0d", occupancy, OCC0 + 3'd2);
        end
        write(2'd1, 8'h11);
        n_checks++;
        if (z_a !== 8'h11 || occupancy !== OCC0 + 3'd2) begin
            n_fail++;
            $display("FAIL rewrite: z_a=%h occ=%0d expected 11 %0d", z_a, occupancy, OCC0 + 3'd2);
        end
    endtask

    task automatic test_hold;
        @(posedge clk);
        x = 8'hEE;
        wr_addr = 2'd1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (z_a !== 8'h11 || z_b !== 8'h3C || occupancy !== OCC0 + 3'd2) begin
            n_fail++;
            $display("FAIL hold: z_a=%h z_b=%h occ=%0d expected 11 3C %0d",
                     z_a, z_b, occupancy, OCC0 + 3'd2);
        end
    endtask

    task automatic test_flush_beats_load;
        @(posedge clk);
        wr_addr = 2'd3;
        x       = 8'hFF;
        load    = 1'b1;
        flush   = 1'b1;
        @(negedge clk);
        #1;
        load  = 1'b0;
        flush = 1'b0;
        rd_addr_a = 2'd3;
        rd_addr_b = 2'd1;
        #1;
        n_checks++;
        if (z_a !== 8'h00 || valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_load_dropped: z_a=%h va=%b expected 00 0", z_a, valid_a);
        end
        n_checks++;
        if (z_b !== 8'h00 || valid_b !== 1'b0 || occupancy !== OCC0) begin
            n_fail++;
            $display("FAIL flush_clear: z_b=%h vb=%b occ=%0d expected 00 0 %0d",
                     z_b, valid_b, occupancy, OCC0);
        end
    endtask

    task automatic test_read_during_write;
        write(2'd2, 8'h55);
        @(posedge clk);
        rd_addr_a = 2'd2;
        wr_addr   = 2'd2;
        x         = 8'h77;
        load      = 1'b1;
        #1;
        n_checks++;
        if (z_a !== 8'h55) begin
            n_fail++;
            $display("FAIL rdw_before: z_a=%h expected 55", z_a);
        end
        @(negedge clk);
        #1;
        load = 1'b0;
        n_checks++;
        if (z_a !== 8'h77) begin
            n_fail++;
            $display("FAIL rdw_after: z_a=%h expected 77", z_a);
        end
    endtask

    task automatic test_fill_saturate;
        word_t      d;
        logic [2:0] exp_occ;
        @(posedge clk);
        flush = 1'b1;
        @(negedge clk);
        #1;
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = word_t'(8'h10 * (i + 1));
            write(2'(i), d);
            exp_occ = 3'(i + 1);
            n_checks++;
            if (occupancy !== exp_occ) begin
                n_fail++;
                $display("FAIL fill_occ[%0d]: got %0d expected %0d", i, occupancy, exp_occ);
            end
        end
        for (int i = 0; i < 4; i++) begin
            write(2'(i), 8'hC0);
        end
        n_checks++;
        if (occupancy !== 3'd4) begin
            n_fail++;
            $display("FAIL saturate_occ: got %0d expected 4", occupancy);
        end
        rd_addr_a = 2'd3;
        rd_addr_b = 2'd3;
        #1;
        n_checks++;
        if (z_a !== 8'hC0 || z_b !== 8'hC0 || valid_a !== 1'b1 || valid_b !== 1'b1) begin
            n_fail++;
            $display("FAIL same_entry: z_a=%h z_b=%h expected C0 C0", z_a, z_b);
        end
    endtask

    task automatic test_async_clear;
        rd_addr_a = 2'd2;
        rd_addr_b = 2'd3;
        @(posedge clk);
        #2;
        clear   = 1'b0;
        wr_addr = 2'd2;
        x       = 8'h5A;
        load    = 1'b1;
        #1;
        n_checks++;
        if (z_a !== 8'h00 || z_b !== 8'h00 || valid_a !== 1'b0 || valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear: z_a=%h z_b=%h va=%b vb=%b expected 00 00 0 0",
                     z_a, z_b, valid_a, valid_b);
        end
        n_checks++;
        if (occupancy !== OCC0) begin
            n_fail++;
            $display("FAIL async_clear_occ: got %0d expected %0d", occupancy, OCC0);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (z_a !== 8'h00 || occupancy !== OCC0) begin
            n_fail++;
            $display("FAIL clear_hold: z_a=%h occ=%0d expected 00 %0d", z_a, occupancy, OCC0);
        end
        load = 1'b0;
        @(posedge clk);
        clear = 1'b1;
    endtask

`ifdef REG_BANK_ZERO0_EN
    task automatic test_zero0;
        write(2'd0, 8'h99);
        rd_addr_a = 2'd0;
        #1;
        n_checks++;
        if (z_a !== 8'h00 || valid_a !== 1'b1 || occupancy !== 3'd1) begin
            n_fail++;
            $display("FAIL zero0: z_a=%h va=%b occ=%0d expected 00 1 1", z_a, valid_a, occupancy);
        end
    endtask
`endif

    initial begin
        clear = 1'b0;
        load = 1'b0;
        flush = 1'b0;
        wr_addr = '0;
        x = '0;
        rd_addr_a = 2'd1;
        rd_addr_b = 2'd2;
        test_reset();
        test_write();
        test_hold();
        test_flush_beats_load();
        test_read_during_write();
        test_fill_saturate();
        test_async_clear();
`ifdef REG_BANK_ZERO0_EN
        test_zero0();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
